seven_segment_scan_driver: RTL and testbench
============================================

SEVEN_SEGMENT_SCAN_DRIVER -- requirements
Module: seven_segment_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 12500, clock cycles per digit slot; legal range >= 2.
REQ-002 Parameter BLANK_CYCLES, default 250, blanked cycles at the start of each slot (anti-ghosting); legal range 1 <= BLANK_CYCLES < REFRESH_DIV.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  display enable; 0 forces all outputs to the off state.
REQ-006 digit  input  [7:0][3:0] packed  digit codes; digit[i] is position i; position 0 is rightmost.
REQ-007 en_dot  input  8  decimal-point enable per position, 1 = dot lit.
REQ-008 an  output  8  anode selects, active-low; an[i] drives position i.
REQ-009 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal-point cathode, active-low.
REQ-011 frame_done  output  1  one-cycle pulse marking completion of a full 8-digit scan.

Function
REQ-012 Slot counter cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; its width SHALL be $clog2(REFRESH_DIV).
REQ-013 Position index idx (3 bits) SHALL increment only when cnt wraps, sequencing 0,1,...,7, then wrapping 7->0.
REQ-014 cnt and idx SHALL run continuously, regardless of en.
REQ-015 Snapshot: on every rising edge where the pre-edge state is idx=0 and cnt=0, the block SHALL latch digit and en_dot into shadow registers.
REQ-016 Display SHALL use only the shadow registers, so input changes become visible only from the next frame; no tearing within a frame.
REQ-017 an, seg, dp and frame_done SHALL be registered; the values after edge n SHALL be a function of the (idx, cnt, shadow, en) values held before edge n (one-cycle latency).
REQ-018 Blanking: if cnt < BLANK_CYCLES or en = 0, the outputs SHALL be an = 8'hFF, seg = 7'h7F, dp = 1.
REQ-019 Otherwise an SHALL be all ones except bit idx, which is 0.
REQ-020 In the same display case, seg SHALL equal decode(shadow_digit[idx]).
REQ-021 In the same display case, dp SHALL equal ~shadow_en_dot[idx].
REQ-022 decode (hex, active-low gfedcba): 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:7F.
REQ-023 Code 4'hF is the blank code: seg = 7'h7F, while an still selects the position and dp still follows en_dot.
REQ-024 frame_done SHALL be 1 for exactly one cycle after each edge where the pre-edge state is idx=7 and cnt=REFRESH_DIV-1, and 0 otherwise.
REQ-025 Frame period SHALL be exactly 8*REFRESH_DIV cycles.
REQ-026 Each position SHALL be driven for exactly REFRESH_DIV-BLANK_CYCLES consecutive cycles per frame.
REQ-027 At most one an bit SHALL be 0 in any cycle.
REQ-028 No two positions SHALL ever be selected on consecutive cycles without at least BLANK_CYCLES blank cycles between them.
REQ-029 Toggling en mid-frame SHALL NOT alter cnt, idx, the shadow registers or frame_done timing.
REQ-030 When en is toggled mid-frame, the effect on an, seg and dp SHALL appear on the next edge.

Reset
REQ-031 While rst = 1: cnt = 0, idx = 0, all shadow digits = 4'hF, shadow en_dot = 8'h00.
REQ-032 While rst = 1: an = 8'hFF, seg = 7'h7F, dp = 1, frame_done = 0.
REQ-033 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-034 After release, scanning SHALL restart at position 0, and the first edge SHALL take a snapshot per REQ-015.

Verification
REQ-035 Scenario 1, setup: REFRESH_DIV=4, BLANK_CYCLES=1; digit[0]=3, en_dot=8'h01, other digits F, en=1; release reset.
  - Edge 1: outputs blank.
  - Edges 2-4: an=8'hFE, seg=7'h30, dp=0.
  - Edge 5: blank.
  - Edge 6: an=8'hFD, seg=7'h7F, dp=1.
REQ-036 Scenario 2, same setup: frame_done=1 only in the cycle after edge 32, and again after edge 64; it is 0 elsewhere.
REQ-037 Scenario 3, same setup: change digit[0] to 4'hA at cycle 10 -> seg stays 7'h30 for position 0 through the current frame; seg=7'h08 from edge 34.
REQ-038 Scenario 4: drop en at cycle 12 for 5 cycles -> an=8'hFF, seg=7'h7F, dp=1 from edge 13 to edge 17; scanning resumes in phase; frame_done timing is unchanged.
REQ-039 Scenario 5: assert rst asynchronously mid-slot at idx=5 -> outputs go to reset values immediately; after release the sequence matches Scenario 1 from edge 1.
REQ-040 Scenario 6: sweep digit codes 0..F on position 0 over 16 frames -> seg matches the REQ-022 table for every code.
REQ-041 Continuous assertions: an is never anything other than 8'hFF or one-cold; REQ-028 holds in every cycle.

Source files
------------

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Scans one position per slot, blanks the start of each slot, and displays a
// frame-coherent snapshot of the digit/dot inputs.
module seven_segment_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 12500,
  parameter int unsigned BLANK_CYCLES = 250
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [7:0][3:0] digit,
  input  logic [7:0]      en_dot,
  output logic [7:0]      an,
  output logic [6:0]      seg,
  output logic            dp,
  output logic            frame_done
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0][3:0]  shadow_digit;
  logic [7:0]       shadow_en_dot;

  logic             cnt_wrap;
  logic             frame_start;
  logic             frame_end;
  logic             show;
  logic [3:0]       cur_code;
  logic [6:0]       seg_dec;

  // Slot/frame boundary decode and display qualification
  always_comb begin
    cnt_wrap    = (cnt == CNT_MAX);
    frame_start = (idx == 3'd0) && (cnt == '0);
    frame_end   = (idx == 3'd7) && cnt_wrap;
    show        = en && (cnt >= BLANK_END);
    cur_code    = shadow_digit[idx];
  end

  // Hex to active-low gfedcba; F is the blank code
  always_comb begin
    seg_dec = 7'h7F;
    case (cur_code)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      default: seg_dec = 7'h7F;
    endcase
  end

  // Free-running slot counter and position index; en has no effect here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (cnt_wrap) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Capture inputs once per frame so a frame never mixes old and new data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_digit  <= {8{4'hF}};
      shadow_en_dot <= 8'h00;
    end else if (frame_start) begin
      shadow_digit  <= digit;
      shadow_en_dot <= en_dot;
    end
  end

  // Registered display outputs and end-of-frame pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (show) begin
        an  <= ~(8'h01 << idx);
        seg <= seg_dec;
        dp  <= ~shadow_en_dot[idx];
      end else begin
        an  <= 8'hFF;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver: fixed scenario table, async reset,
// code sweep and randomized inputs checked against a time-based model.
module tb_seven_segment_scan_driver;

  localparam int RD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = 8 * RD;

  logic            clk;
  logic            rst;
  logic            en;
  logic [7:0][3:0] digit;
  logic [7:0]      en_dot;
  logic [7:0]      an;
  logic [6:0]      seg;
  logic            dp;
  logic            frame_done;

  seven_segment_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .en(en), .digit(digit), .en_dot(en_dot),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } vec_t;

  vec_t tbl [$];

  logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  // Model state: edges elapsed since reset release plus captured frame data
  int              m_t;
  logic [7:0][3:0] m_dig;
  logic [7:0]      m_dot;
  logic [7:0]      last_an;
  bit              have_last;
  int              gap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, edge_n, act, req);
    end
  endtask

  task automatic model_reset();
    m_t       = 0;
    m_dig     = {8{4'hF}};
    m_dot     = 8'h00;
    have_last = 0;
    gap       = 0;
    edge_n    = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_an"},  32'(an),  32'hFF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"},  32'(dp),  32'h1);
    chk({tag, "_fd"},  32'(frame_done), 32'h0);
  endtask

  // One clock edge: predict from slot timing, advance, compare, check invariants
  task automatic step();
    int         c;
    logic [2:0] p;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fd;
    c = m_t % RD;
    p = 3'((m_t / RD) % 8);
    if (c < BC || !en) begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = ~(8'h01 << p);
      e_seg = dec_tbl[m_dig[p]];
      e_dp  = ~m_dot[p];
    end
    e_fd = ((m_t % FRAME) == FRAME - 1);
    if ((m_t % FRAME) == 0) begin
      m_dig = digit;
      m_dot = en_dot;
    end
    m_t++;
    @(posedge clk);
    #1;
    edge_n++;
    chk("model_an",  32'(an),  32'(e_an));
    chk("model_seg", 32'(seg), 32'(e_seg));
    chk("model_dp",  32'(dp),  32'(e_dp));
    chk("model_fd",  32'(frame_done), 32'(e_fd));
    chk("an_onecold", 32'($onehot0(~an)), 32'h1);
    if (an != 8'hFF) begin
      if (have_last && an != last_an) chk("blank_gap", 32'(gap >= BC), 32'h1);
      last_an   = an;
      have_last = 1;
      gap       = 0;
    end else begin
      gap++;
    end
  endtask

  task automatic chk_tbl(input int max_edge);
    foreach (tbl[i]) begin
      if (tbl[i].edge_no == edge_n && edge_n <= max_edge) begin
        chk("tbl_an",  32'(an),  32'(tbl[i].an));
        chk("tbl_seg", 32'(seg), 32'(tbl[i].seg));
        chk("tbl_dp",  32'(dp),  32'(tbl[i].dp));
        chk("tbl_fd",  32'(frame_done), 32'(tbl[i].fd));
      end
    end
  endtask

  task automatic setup_inputs();
    en        = 1'b1;
    digit     = {8{4'hF}};
    digit[0]  = 4'h3;
    en_dot    = 8'h01;
  endtask

  initial begin
    // Expected outputs per edge after reset release (scenarios 1-4)
    tbl.push_back('{1,  8'hFF, 7'h7F, 1'b1, 1'b0});
    tbl.push_back('{2,  8'hFE, 7'h30, 1'b0, 1'b0});
    tbl.push_back('{3,  8'hFE, 7'h30, 1'b0, 1'b0});
    tbl.push_back('{4,  8'hFE, 7'h30, 1'b0, 1'b0});
    tbl.push_back('{5,  8'hFF, 7'h7F, 1'b1, 1'b0});
    tbl.push_back('{6,  8'hFD, 7'h7F, 1'b1, 1'b0});
    tbl.push_back('{14, 8'hFF, 7'h7F, 1'b1, 1'b0});
    tbl.push_back('{17, 8'hFF, 7'h7F, 1'b1, 1'b0});
    tbl.push_back('{18, 8'hEF, 7'h7F, 1'b1, 1'b0});
    tbl.push_back('{31, 8'h7F, 7'h7F, 1'b1, 1'b0});
    tbl.push_back('{32, 8'h7F, 7'h7F, 1'b1, 1'b1});
    tbl.push_back('{33, 8'hFF, 7'h7F, 1'b1, 1'b0});
    tbl.push_back('{34, 8'hFE, 7'h08, 1'b0, 1'b0});
    tbl.push_back('{63, 8'h7F, 7'h7F, 1'b1, 1'b0});
    tbl.push_back('{64, 8'h7F, 7'h7F, 1'b1, 1'b1});
    tbl.push_back('{65, 8'hFF, 7'h7F, 1'b1, 1'b0});

    rst = 1'b1;
    setup_inputs();
    #1;
    chk_reset_outs("rst_init");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst_held");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Scenarios 1-4: scan, frame pulse, snapshot latency, en drop
    while (edge_n < 66) begin
      step();
      chk_tbl(66);
      if (edge_n == 10) digit[0] = 4'hA;
      if (edge_n == 12) en = 1'b0;
      if (edge_n == 17) en = 1'b1;
    end

    // Scenario 5: async reset mid-slot at position 5
    while (!(((m_t - 1) % RD) == 2 && (((m_t - 1) / RD) % 8) == 5)) step();
    chk("pre_rst_an", 32'(an), 32'hDF);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outs("rst_async");
    setup_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    while (edge_n < 8) begin
      step();
      chk_tbl(8);
    end

    // Scenario 6: sweep all codes on position 0, one per frame
    while ((m_t % FRAME) != 0) step();
    for (int code = 0; code < 16; code++) begin
      digit[0] = 4'(code);
      en_dot   = 8'(code & 1);
      repeat (BC + 1) step();
      chk("sweep_seg", 32'(seg), 32'(dec_tbl[code]));
      chk("sweep_dp",  32'(dp),  32'((code & 1) == 0));
      repeat (FRAME - BC - 1) step();
    end

    // Randomized inputs and enable toggling against the model
    for (int i = 0; i < 20 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        digit  = {$urandom, $urandom};
        en_dot = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) en = ~en;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
